// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan sequencer and its requester/mux.
// master = requester and mux side, slave = sequencer.
interface mux_scan_ctrl_if;
    logic       start;
    logic       cont;
    logic [3:0] mask;
    logic       y;
    logic [1:0] s;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    modport master (
        output start, cont, mask, y,
        input  s, sample, valid, busy
    );

    modport slave (
        input  start, cont, mask, y,
        output s, sample, valid, busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for a 4:1 select mux: steps s over the enabled channels,
// lets each settle for DWELL cycles, captures y and publishes a 4-bit snapshot.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic           clk,
    input  logic           rst,
    mux_scan_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURE, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]       mask_q;
    logic [3:0]       shadow;
    logic [3:0]       shadow_cap;
    logic [1:0]       s_q;
    logic [3:0]       sample_q;
    logic             valid_q;
    logic             busy_q;
    logic [2:0]       nxt;

    function automatic logic [1:0] low_bit(input logic [3:0] m);
        low_bit = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (m[i]) low_bit = 2'(i);
    endfunction

    // Returns {found, index} of the next enabled channel above cur.
    function automatic logic [2:0] next_bit(input logic [3:0] m, input logic [1:0] cur);
        next_bit = 3'b000;
        for (int i = 3; i >= 0; i--)
            if (m[i] && (i > int'(cur))) next_bit = {1'b1, 2'(i)};
    endfunction

    // Shadow including the bit captured this cycle, so DONE can publish it on entry.
    always_comb begin
        shadow_cap      = shadow;
        shadow_cap[s_q] = bus.y;
        nxt             = next_bit(mask_q, s_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            mask_q   <= 4'd0;
            shadow   <= 4'd0;
            s_q      <= 2'd0;
            sample_q <= 4'd0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        mask_q <= bus.mask;
                        shadow <= 4'd0;
                        busy_q <= 1'b1;
                        if (bus.mask != 4'd0) begin
                            s_q   <= low_bit(bus.mask);
                            cnt   <= '0;
                            state <= SETTLE;
                        end else begin
                            sample_q <= 4'd0;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt == CNT_LAST) state <= CAPTURE;
                    else                 cnt   <= cnt + 1'b1;
                end
                CAPTURE: begin
                    shadow <= shadow_cap;
                    if (nxt[2]) begin
                        s_q   <= nxt[1:0];
                        cnt   <= '0;
                        state <= SETTLE;
                    end else begin
                        sample_q <= shadow_cap;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (bus.cont) begin
                        shadow <= 4'd0;
                        if (mask_q != 4'd0) begin
                            s_q   <= low_bit(mask_q);
                            cnt   <= '0;
                            state <= SETTLE;
                        end else begin
                            // Empty continuous scan: stay here, one valid per cycle.
                            sample_q <= 4'd0;
                            valid_q  <= 1'b1;
                        end
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.s      = s_q;
    assign bus.sample = sample_q;
    assign bus.valid  = valid_q;
    assign bus.busy   = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: reset abort, full/sparse/empty scans,
// continuous mode and start held high with a mid-scan mask change.
module tb_mux_scan_ctrl;

    localparam int DWELL = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_vec;
    int         n_chk  = 0;
    int         n_fail = 0;
    int         lat;
    bit         hold;
    logic [1:0] trace[$];

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.DWELL(DWELL), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Combinational 4:1 mux feeding y back from the selected input.
    assign bus.y = in_vec[bus.s];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Waits for valid after the next edge, recording s on every non-valid cycle.
    task automatic wait_valid();
        lat = 0;
        trace.delete();
        do begin
            tick();
            lat++;
            if (lat == 1) begin
                if (hold) bus.mask = 4'b1111;
                else      bus.start = 1'b0;
            end
            if (bus.valid !== 1'b1) trace.push_back(bus.s);
        end while (bus.valid !== 1'b1 && lat < 100);
    endtask

    task automatic scan(input logic [3:0] m);
        bus.mask  = m;
        bus.start = 1'b1;
        wait_valid();
    endtask

    function automatic int trace_err(input logic [3:0] m);
        int idx = 0;
        int err = 0;
        for (int ch = 0; ch < 4; ch++)
            if (m[ch])
                for (int k = 0; k < DWELL + 1; k++) begin
                    if (idx >= trace.size() || trace[idx] !== 2'(ch)) err++;
                    idx++;
                end
        if (idx != trace.size()) err++;
        return err;
    endfunction

    initial begin
        rst = 1'b1; bus.start = 1'b0; bus.cont = 1'b0; bus.mask = 4'd0;
        in_vec = 4'd0; hold = 1'b0;
        tick(); tick();
        chk("rst_s", bus.s, 2'd0);
        chk("rst_sample", bus.sample, 4'd0);
        chk("rst_valid", bus.valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst = 1'b0;
        tick();

        // Reset during SETTLE of channel 2
        in_vec = 4'b1111; bus.mask = 4'b1111; bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("abort_busy_on", bus.busy, 1'b1);
        for (int i = 0; i < 30 && bus.s !== 2'd2; i++) tick();
        chk("abort_reach_ch2", bus.s, 2'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_s", bus.s, 2'd0);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_valid", bus.valid, 1'b0);
        chk("abort_sample", bus.sample, 4'd0);
        tick(); tick(); tick();
        chk("abort_idle_busy", bus.busy, 1'b0);
        chk("abort_idle_valid", bus.valid, 1'b0);

        // Full scan
        in_vec = 4'b1010;
        scan(4'b1111);
        chk("full_lat", lat, 21);
        chk("full_sample", bus.sample, 4'b1010);
        chk("full_trace", trace_err(4'b1111), 0);
        tick();
        chk("full_busy_drop", bus.busy, 1'b0);
        chk("full_valid_pulse", bus.valid, 1'b0);

        // Sparse mask
        in_vec = 4'b1111;
        scan(4'b0101);
        chk("sparse_lat", lat, 11);
        chk("sparse_sample", bus.sample, 4'b0101);
        chk("sparse_trace", trace_err(4'b0101), 0);
        tick(); tick(); tick();
        chk("sparse_busy_drop", bus.busy, 1'b0);
        chk("sample_hold", bus.sample, 4'b0101);
        chk("s_hold_idle", bus.s, 2'd2);

        // Empty mask
        scan(4'b0000);
        chk("empty_lat", lat, 1);
        chk("empty_sample", bus.sample, 4'd0);
        chk("empty_busy", bus.busy, 1'b1);
        tick();
        chk("empty_idle_busy", bus.busy, 1'b0);
        chk("empty_idle_valid", bus.valid, 1'b0);

        // Continuous mode
        bus.cont = 1'b1; in_vec = 4'b0001;
        scan(4'b0011);
        chk("cont1_lat", lat, 11);
        chk("cont1_sample", bus.sample, 4'b0001);
        in_vec = 4'b0010;
        wait_valid();
        chk("cont2_lat", lat, 11);
        chk("cont2_sample", bus.sample, 4'b0010);
        chk("cont2_trace", trace_err(4'b0011), 0);
        in_vec = 4'b0001;
        tick();
        bus.cont = 1'b0;
        chk("cont3_busy", bus.busy, 1'b1);
        wait_valid();
        chk("cont3_lat", lat, 10);
        chk("cont3_sample", bus.sample, 4'b0001);
        tick();
        chk("cont_end_busy", bus.busy, 1'b0);
        tick(); tick();
        chk("cont_end_valid", bus.valid, 1'b0);

        // start held high, mask changed mid-scan
        hold = 1'b1; in_vec = 4'b1111;
        scan(4'b0011);
        chk("hold_lat", lat, 11);
        chk("hold_sample", bus.sample, 4'b0011);
        chk("hold_trace", trace_err(4'b0011), 0);
        tick();
        chk("hold_idle_busy", bus.busy, 1'b0);
        tick();
        chk("hold_restart_busy", bus.busy, 1'b1);
        chk("hold_restart_s", bus.s, 2'd0);
        hold = 1'b0;
        wait_valid();
        chk("hold_rescan_lat", lat, 20);
        chk("hold_rescan_sample", bus.sample, 4'b1111);
        tick();
        chk("hold_rescan_done", bus.busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
